mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Two-requester arbiter in front of one shared, fixed-latency memory port.
//   An instruction-fetch port and a load/store data port compete for the
//   memory. Ties are broken round-robin. Each transaction runs strictly
//   serially: grant, one issue cycle, LATENCY wait cycles, one response cycle.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   if_req, if_addr               fetch request (held until if_rvalid)
//   if_rvalid, if_rdata           fetch completion strobe and data
//   dm_req, dm_we, dm_addr,
//   dm_wdata, dm_wmask            data request (held until dm_rvalid)
//   dm_rvalid, dm_rdata           load data / store acknowledge strobe and data
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_wmask          shared memory command port
//   mem_rdata                     memory read data, valid LATENCY cycles after mem_en
//   busy                          high whenever a transaction is in progress
//
// State   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate and latch the winning request
// S_ISSUE | drive mem_en for one cycle with the latched command
// S_WAIT  | count LATENCY cycles; capture mem_rdata on the last one
// S_RESP  | pulse the owner's rvalid; requests are ignored this cycle

module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,

    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [31:0]           dm_wdata,
    input  logic [3:0]            dm_wmask,
    output logic                  dm_rvalid,
    output logic [31:0]           dm_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic [31:0]           mem_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Counter value on the final wait cycle.
    localparam logic [3:0] WAIT_LAST = 4'(LATENCY - 1);

    state_t                r_state;
    state_t                w_next;

    // The most recent grant is also the owner of the transaction in flight,
    // so one register serves both the round-robin history and the response
    // routing.
    logic                  r_last_grant;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wmask;
    logic [3:0]            r_cnt;
    logic [31:0]           r_if_rdata;
    logic [31:0]           r_dm_rdata;

    logic                  w_any_req;
    logic                  w_grant_dm;
    logic                  w_wait_done;

    assign w_any_req   = if_req | dm_req;
    // DM wins when it is alone, or on a tie when IF was granted last.
    assign w_grant_dm  = dm_req & (~if_req | (r_last_grant == GRANT_IF));
    assign w_wait_done = (r_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req)   w_next = S_ISSUE;
            S_ISSUE:                  w_next = S_WAIT;
            S_WAIT:  if (w_wait_done) w_next = S_RESP;
            S_RESP:                   w_next = S_IDLE;
            default:                  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_DM;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_cnt        <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_last_grant <= w_grant_dm;
                        if (w_grant_dm) begin
                            r_we    <= dm_we;
                            r_addr  <= dm_addr;
                            r_wdata <= dm_wdata;
                            r_wmask <= dm_wmask;
                        end else begin
                            r_we    <= 1'b0;
                            r_addr  <= if_addr;
                            r_wdata <= '0;
                            r_wmask <= 4'b0000;
                        end
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (!w_wait_done) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (!r_we) begin
                        // Stores never reach here, so dm_rdata keeps the
                        // last loaded word across a store.
                        if (r_last_grant == GRANT_DM) begin
                            r_dm_rdata <= mem_rdata;
                        end else begin
                            r_if_rdata <= mem_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_en    = (r_state == S_ISSUE);
    assign mem_we    = (r_state == S_ISSUE) & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign if_rvalid = (r_state == S_RESP) & (r_last_grant == GRANT_IF);
    assign dm_rvalid = (r_state == S_RESP) & (r_last_grant == GRANT_DM);
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

endmodule
